prng_lane_bank: RTL and testbench

Parametrised multi-lane shift/XOR pseudo-random generator bank. LANES independent generator lanes of configurable WIDTH step in lockstep. Features:
- programmable reseed
- warm-up discard after reset or reseed
- all-zero lock-up detection and recovery
- valid/ready output handshake with backpressure

The bank feeds the test-pattern and scrambler consumers downstream of the generator stage and replaces the fixed 32-bit single-lane generator.

---
 rtl/prng_lane_bank.sv | 156 +++++++++++++++
 tb/tb_prng_lane_bank.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/prng_lane_bank.sv
// prng_lane_bank: LANES lockstep shift/XOR generators with reseed,
// warm-up discard, all-zero recovery and a valid/ready output port.
//
// Ports:
//   clk, rst         clock (rising edge), async active-high reset
//   en               step enable; low freezes all state
//   seed_valid/data  one-cycle reseed request, always accepted
//   out_valid/ready  output handshake; out_data holds lane i at
//                    [i*WIDTH +: WIDTH]
//   busy             high while discarding warm-up steps
//   stuck            sticky per-lane all-zero lock-up flag
module prng_lane_bank #(
    parameter int          WIDTH     = 32,
    parameter int          LANES     = 4,
    parameter logic [31:0] SEED      = 32'hFFFFFFFF,
    parameter logic [31:0] SEED_STEP = 32'h9E3779B9,
    parameter logic [31:0] CONST     = 32'hFFFFFFFF,
    parameter int          SHIFT_L1  = 11,
    parameter int          SHIFT_L2  = 11,
    parameter int          SHIFT_R   = 11,
    parameter int          WARMUP    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   seed_valid,
    input  logic [WIDTH-1:0]       seed_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic                   busy,
    output logic [LANES-1:0]       stuck
);

    localparam logic [WIDTH-1:0] SEED_W  = WIDTH'(SEED);
    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(SEED_STEP);
    localparam logic [WIDTH-1:0] CONST_W = WIDTH'(CONST);
    localparam logic [7:0]       WARM_N  = 8'(WARMUP);

    typedef enum logic {
        WARM,
        RUN
    } state_t;

    state_t           state;
    logic [7:0]       cnt;
    logic [WIDTH-1:0] s_q [LANES];
    logic [WIDTH-1:0] l_q [LANES];
    logic [WIDTH-1:0] r_q [LANES];

    logic [WIDTH-1:0]       s_nx [LANES];
    logic [WIDTH-1:0]       l_nx [LANES];
    logic [WIDTH-1:0]       r_nx [LANES];
    logic [LANES-1:0]       zero;
    logic [LANES*WIDTH-1:0] word_nx;
    logic                   warm_step;
    logic                   run_step;
    logic                   step;

    function automatic logic [WIDTH-1:0] lane_seed(
        input logic [WIDTH-1:0] base,
        input int unsigned      idx
    );
        return base + WIDTH'(idx) * STEP_W;
    endfunction

    // A lane found all-zero reloads its reset seed instead of
    // stepping, so it cannot stay locked at zero (unless that
    // seed is itself zero).
    always_comb begin
        zero    = '0;
        word_nx = '0;
        for (int i = 0; i < LANES; i++) begin
            zero[i] = ~|{s_q[i], l_q[i], r_q[i]};
            if (zero[i]) begin
                s_nx[i] = lane_seed(SEED_W, i);
                l_nx[i] = '0;
                r_nx[i] = '0;
            end else begin
                s_nx[i] = (r_q[i] >> SHIFT_R)
                        ^ (l_q[i] << SHIFT_L2);
                l_nx[i] = (s_q[i] << SHIFT_L1) ^ s_q[i];
                r_nx[i] = s_q[i] & CONST_W;
            end
            word_nx[i*WIDTH +: WIDTH] = s_nx[i];
        end
    end

    assign warm_step = (state == WARM) && en && (cnt != 8'd0);
    assign run_step  = (state == RUN) && en
                     && (!out_valid || out_ready);
    assign step      = warm_step || run_step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                s_q[i] <= lane_seed(SEED_W, i);
                l_q[i] <= '0;
                r_q[i] <= '0;
            end
            state     <= WARM;
            cnt       <= WARM_N;
            busy      <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            stuck     <= '0;
        end else if (seed_valid) begin
            for (int i = 0; i < LANES; i++) begin
                s_q[i] <= lane_seed(seed_data, i);
                l_q[i] <= '0;
                r_q[i] <= '0;
            end
            state     <= WARM;
            cnt       <= WARM_N;
            busy      <= 1'b1;
            out_valid <= 1'b0;
            stuck     <= '0;
        end else begin
            if (step) begin
                for (int i = 0; i < LANES; i++) begin
                    s_q[i] <= s_nx[i];
                    l_q[i] <= l_nx[i];
                    r_q[i] <= r_nx[i];
                end
                stuck <= stuck | zero;
            end
            unique case (state)
                WARM: begin
                    // The last discard step also leaves WARM, so
                    // busy lasts WARMUP cycles (one when WARMUP=0).
                    if (en) begin
                        if (cnt <= 8'd1) begin
                            state <= RUN;
                            busy  <= 1'b0;
                        end
                        if (cnt != 8'd0) begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                end
                RUN: begin
                    if (run_step) begin
                        out_valid <= 1'b1;
                        out_data  <= word_nx;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= WARM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prng_lane_bank.sv
// tb_prng_lane_bank: directed checks of a 1-lane WARMUP=0 bank and
// a 4-lane WARMUP=1 bank against hand-computed words.
module tb_prng_lane_bank;

    logic clk;
    int   checks;
    int   errors;

    logic         a_rst, a_en, a_seed_valid, a_out_ready;
    logic [31:0]  a_seed_data;
    logic         a_out_valid, a_busy;
    logic [31:0]  a_out_data;
    logic [0:0]   a_stuck;

    logic         b_rst, b_en, b_seed_valid, b_out_ready;
    logic [31:0]  b_seed_data;
    logic         b_out_valid, b_busy;
    logic [127:0] b_out_data;
    logic [3:0]   b_stuck;

    prng_lane_bank #(
        .WIDTH (32),
        .LANES (1),
        .WARMUP(0)
    ) u_a (
        .clk       (clk),
        .rst       (a_rst),
        .en        (a_en),
        .seed_valid(a_seed_valid),
        .seed_data (a_seed_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .busy      (a_busy),
        .stuck     (a_stuck)
    );

    prng_lane_bank #(
        .WIDTH (32),
        .LANES (4),
        .WARMUP(1)
    ) u_b (
        .clk       (clk),
        .rst       (b_rst),
        .en        (b_en),
        .seed_valid(b_seed_valid),
        .seed_data (b_seed_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .busy      (b_busy),
        .stuck     (b_stuck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(
        input string        tag,
        input logic [127:0] got,
        input logic [127:0] exp
    );
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        a_rst        = 1'b1;
        a_en         = 1'b1;
        a_seed_valid = 1'b0;
        a_seed_data  = '0;
        a_out_ready  = 1'b1;
        b_rst        = 1'b1;
        b_en         = 1'b1;
        b_seed_valid = 1'b0;
        b_seed_data  = '0;
        b_out_ready  = 1'b1;

        tick();
        chk("a_rst_valid", a_out_valid, 0);
        chk("a_rst_data", a_out_data, 0);
        chk("a_rst_busy", a_busy, 1);
        chk("a_rst_stuck", a_stuck, 0);
        chk("b_rst_busy", b_busy, 1);
        chk("b_rst_data", b_out_data, 0);
        chk("b_rst_stuck", b_stuck, 0);

        // 1-lane bank, WARMUP=0: WARM exits on first edge
        a_rst = 1'b0;
        tick();
        chk("a_e1_busy", a_busy, 0);
        chk("a_e1_valid", a_out_valid, 0);
        tick();
        chk("a_w1_valid", a_out_valid, 1);
        chk("a_w1", a_out_data, 32'h00000000);
        tick();
        chk("a_w2", a_out_data, 32'h002007FF);
        tick();
        chk("a_w3", a_out_data, 32'h00000000);

        a_out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("a_hold_valid", a_out_valid, 1);
            chk("a_hold_data", a_out_data, 32'h00000000);
        end
        a_out_ready = 1'b1;
        tick();
        chk("a_w4", a_out_data, 32'hFFFFFC00);
        tick();
        chk("a_w5", a_out_data, 32'h00000000);
        tick();
        chk("a_w6", a_out_data, 32'hFFFFFFFF);

        // consumer takes the word while stepping is disabled
        a_en = 1'b0;
        tick();
        chk("a_en0_valid", a_out_valid, 0);
        chk("a_en0_data", a_out_data, 32'hFFFFFFFF);
        a_en = 1'b1;
        tick();
        chk("a_w7_valid", a_out_valid, 1);
        chk("a_w7", a_out_data, 32'h00000000);
        tick();
        chk("a_w8", a_out_data, 32'h002007FF);

        // asynchronous reset mid-stream
        a_rst = 1'b1;
        #1;
        chk("a_arst_valid", a_out_valid, 0);
        chk("a_arst_data", a_out_data, 0);
        chk("a_arst_busy", a_busy, 1);
        chk("a_arst_stuck", a_stuck, 0);
        tick();
        a_rst = 1'b0;
        tick();
        chk("a_r_e1_valid", a_out_valid, 0);
        tick();
        chk("a_r_w1", a_out_data, 32'h00000000);
        tick();
        chk("a_r_w2_valid", a_out_valid, 1);
        chk("a_r_w2", a_out_data, 32'h002007FF);

        // reseed together with a handshake drops the word
        a_seed_valid = 1'b1;
        a_seed_data  = 32'hFFFFFFFF;
        tick();
        a_seed_valid = 1'b0;
        chk("a_rs_valid", a_out_valid, 0);
        chk("a_rs_busy", a_busy, 1);
        tick();
        chk("a_rs_e1_valid", a_out_valid, 0);
        chk("a_rs_e1_busy", a_busy, 0);
        tick();
        chk("a_rs_w1_valid", a_out_valid, 1);
        chk("a_rs_w1", a_out_data, 32'h00000000);
        tick();
        chk("a_rs_w2", a_out_data, 32'h002007FF);

        // 4-lane bank, WARMUP=1
        b_rst = 1'b0;
        tick();
        chk("b_e1_busy", b_busy, 0);
        chk("b_e1_valid", b_out_valid, 0);
        tick();
        chk("b_w1_valid", b_out_valid, 1);
        chk("b_w1_l0", b_out_data[31:0], 32'h002007FF);
        chk("b_w1_l1", b_out_data[63:32], 32'hD5DE06EF);
        chk("b_w1_stuck", b_stuck, 0);

        // reseed to zero: lane 0 locks up and recovers
        b_seed_valid = 1'b1;
        b_seed_data  = 32'h00000000;
        tick();
        b_seed_valid = 1'b0;
        chk("b_rs_valid", b_out_valid, 0);
        chk("b_rs_busy", b_busy, 1);
        chk("b_rs_stuck", b_stuck, 0);
        tick();
        chk("b_lk_stuck", b_stuck, 4'b0001);
        chk("b_lk_busy", b_busy, 0);
        chk("b_lk_valid", b_out_valid, 0);
        tick();
        chk("b_lk_w1_valid", b_out_valid, 1);
        chk("b_lk_w1_l0", b_out_data[31:0], 32'h00000000);
        chk("b_lk_w1_l1", b_out_data[63:32], 32'hD59E0EEF);
        chk("b_lk_w1_stuck", b_stuck, 4'b0001);
        tick();
        chk("b_lk_w2_l0", b_out_data[31:0], 32'h002007FF);
        chk("b_lk_w2_stuck", b_stuck, 4'b0001);

        b_seed_valid = 1'b1;
        b_seed_data  = 32'hFFFFFFFF;
        tick();
        b_seed_valid = 1'b0;
        chk("b_rs2_stuck", b_stuck, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
